// File: rtl/prog_sequencer_pkg.sv
// Shared types for the program sequencer: FSM states and next-PC mux select.
// Imported by the sequencer top; no logic lives here.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    NPC_HOLD = 2'd0,
    NPC_RET  = 2'd1,
    NPC_TARG = 2'd2,
    NPC_INC  = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/prog_sequencer_if.sv
// Control/fetch bundle between the control unit, instruction ROM and sequencer.
// CycleCount exists only when SEQ_CYCLE_COUNT_EN is defined.
interface prog_sequencer_if #(parameter int PC_W = 12);

  logic            Start;
  logic            Stall;
  logic            Halt;
  logic            JumpAbs;
  logic            BranchAbsEn;
  logic            ALU_flag;
  logic            Call;
  logic            Ret;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;
  logic            Running;
  logic            Done;
  logic            RasErr;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0]     CycleCount;
`endif

  modport master (
    output Start, Stall, Halt, JumpAbs, BranchAbsEn, ALU_flag, Call, Ret, Target,
`ifdef SEQ_CYCLE_COUNT_EN
    input  CycleCount,
`endif
    input  ProgCtr, Running, Done, RasErr
  );

  modport slave (
    input  Start, Stall, Halt, JumpAbs, BranchAbsEn, ALU_flag, Call, Ret, Target,
`ifdef SEQ_CYCLE_COUNT_EN
    output CycleCount,
`endif
    output ProgCtr, Running, Done, RasErr
  );

endinterface

// File: rtl/prog_sequencer_ret_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Latency 1 cycle; no backpressure, err_pulse flags overflow/underflow combinationally.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_dec;
  logic [PTR_W:0]   cnt_q, cnt_d;

  // ptr_q is the next write slot; when full it also points at the oldest entry.
  assign ptr_dec   = ptr_q - PTR_W'(1);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_MAX);
  assign top       = mem_q[ptr_dec];
  assign err_pulse = !clear && ((pop && empty) || (push && !pop && full));

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (pop) begin
      if (!empty) begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - (PTR_W+1)'(1);
      end
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, run/done FSM, call/return stack; optional SEQ_CYCLE_COUNT_EN counter.
// Latency 1 cycle (ProgCtr updates on the edge after decode); Stall holds PC, stack and state.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W       = 12,
  parameter int              RAS_DEPTH  = 4,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input logic              Clk,
  input logic              Reset,
  prog_sequencer_if.slave  sq
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, stk_top;
  logic            running_q, running_d, done_q, done_d, ras_err_q, ras_err_d;
  logic            active, ret_go, call_go, stk_empty, stk_err, unused_full;
  npc_sel_t        npc_sel;

  assign pc_inc  = pc_q + PC_W'(1);
  assign active  = (state_q == RUN) && !sq.Stall && !sq.Start;
  assign ret_go  = active && !sq.Halt && sq.Ret;
  assign call_go = active && !sq.Halt && !sq.Ret && sq.Call;

  ret_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk       (Clk),
    .rst       (Reset),
    .push      (call_go),
    .pop       (ret_go),
    .clear     (sq.Start),
    .push_data (pc_inc),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (unused_full),
    .err_pulse (stk_err)
  );

  always_comb begin
    npc_sel = NPC_INC;
    if (!active || sq.Halt)                                              npc_sel = NPC_HOLD;
    else if (sq.Ret)                                                     npc_sel = stk_empty ? NPC_INC : NPC_RET;
    else if (sq.Call || sq.JumpAbs || (sq.BranchAbsEn && sq.ALU_flag))   npc_sel = NPC_TARG;
  end

  always_comb begin
    state_d   = state_q;
    ras_err_d = ras_err_q | stk_err;
    case (npc_sel)
      NPC_RET:  pc_d = stk_top;
      NPC_TARG: pc_d = sq.Target;
      NPC_INC:  pc_d = pc_inc;
      default:  pc_d = pc_q;
    endcase
    if (sq.Start) begin
      state_d   = RUN;
      pc_d      = START_ADDR;
      ras_err_d = 1'b0;
    end else if (active && sq.Halt) begin
      state_d = DONE;
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      ras_err_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ras_err_q <= ras_err_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign sq.ProgCtr = pc_q;
  assign sq.Running = running_q;
  assign sq.Done    = done_q;
  assign sq.RasErr  = ras_err_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Counts stalled RUN cycles too; freezes outside RUN and saturates.
  always_comb begin
    cyc_d = cyc_q;
    if (sq.Start)                            cyc_d = '0;
    else if (state_q == RUN && cyc_q != '1)  cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign sq.CycleCount = cyc_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed plus random bench for prog_sequencer against a queue-based reference model.
module tb_prog_sequencer;

  localparam int              PC_W  = 12;
  localparam int              DEPTH = 4;
  localparam logic [PC_W-1:0] START = '0;
  localparam int unsigned     PC_MOD = 32'd1 << PC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_sequencer_if #(.PC_W(PC_W)) sq_if ();

  prog_sequencer #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .START_ADDR(START)) dut (
    .Clk   (clk),
    .Reset (rst),
    .sq    (sq_if)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: state 0=idle 1=run 2=done.
  int unsigned m_pc;
  int          m_state;
  bit          m_err;
  int unsigned m_stk[$];
  int unsigned m_cc;

  task automatic model_reset();
    m_pc = START; m_state = 0; m_err = 0; m_stk.delete(); m_cc = 0;
  endtask

  task automatic model_step();
    if (sq_if.Start) begin
      m_cc = 0; m_pc = START; m_stk.delete(); m_err = 0; m_state = 1;
      return;
    end
    if (m_state == 1 && m_cc != 32'hFFFF_FFFF) m_cc++;
    if (m_state != 1 || sq_if.Stall) return;
    if (sq_if.Halt) m_state = 2;
    else if (sq_if.Ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = (m_pc + 1) % PC_MOD; m_err = 1; end
    end else if (sq_if.Call) begin
      if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); m_err = 1; end
      m_stk.push_back((m_pc + 1) % PC_MOD);
      m_pc = sq_if.Target;
    end else if (sq_if.JumpAbs) m_pc = sq_if.Target;
    else if (sq_if.BranchAbsEn && sq_if.ALU_flag) m_pc = sq_if.Target;
    else m_pc = (m_pc + 1) % PC_MOD;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".ProgCtr"}, 32'(sq_if.ProgCtr), m_pc);
    check({ctx, ".Running"}, 32'(sq_if.Running), 32'(m_state == 1));
    check({ctx, ".Done"},    32'(sq_if.Done),    32'(m_state == 2));
    check({ctx, ".RasErr"},  32'(sq_if.RasErr),  32'(m_err));
`ifdef SEQ_CYCLE_COUNT_EN
    check({ctx, ".CycleCount"}, sq_if.CycleCount, m_cc);
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare 1 time unit later.
  task automatic cyc(input string ctx, input bit st, sl, hl, rt, ca, jp, br, fl,
                     input int unsigned tg);
    sq_if.Start = st; sq_if.Stall = sl; sq_if.Halt = hl; sq_if.Ret = rt;
    sq_if.Call = ca; sq_if.JumpAbs = jp; sq_if.BranchAbsEn = br; sq_if.ALU_flag = fl;
    sq_if.Target = PC_W'(tg);
    @(posedge clk);
    model_step();
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) cyc(ctx, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    sq_if.Start = 0; sq_if.Stall = 0; sq_if.Halt = 0; sq_if.Ret = 0;
    sq_if.Call = 0; sq_if.JumpAbs = 0; sq_if.BranchAbsEn = 0; sq_if.ALU_flag = 0;
    sq_if.Target = '0;
    model_reset();
    #12;
    check_all("reset");
    #1 rst = 1'b0;

    // Start then free-run: 0,1,2,3,4,5
    cyc("start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("count", 5);
    check("pc_after_count", 32'(sq_if.ProgCtr), 32'd5);

    // Call from 7 to 40, return to 8
    idle("to7", 2);
    cyc("call40", 0, 0, 0, 0, 1, 0, 0, 0, 40);
    idle("sub", 3);
    cyc("ret8", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("ret_pc8", 32'(sq_if.ProgCtr), 32'd8);

    // Five nested calls overflow a 4-deep stack, five returns underflow once
    cyc("jmp1", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc("ncall", 0, 0, 0, 0, 1, 0, 0, 0, 10 * k + 10);
      if (k < 4) idle("nstep", 1);
    end
    for (int k = 0; k < 5; k++) cyc("nret", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("underflow_pc", 32'(sq_if.ProgCtr), 32'd13);

    // Ret and Call together: Ret wins, no push
    cyc("retcall", 0, 0, 0, 1, 1, 0, 0, 0, 300);

    // Branch not taken, taken, then stalled jumps hold
    cyc("br_nt", 0, 0, 0, 0, 0, 0, 1, 0, 100);
    cyc("br_t", 0, 0, 0, 0, 0, 0, 1, 1, 100);
    cyc("stall1", 0, 1, 0, 0, 0, 1, 0, 0, 200);
    cyc("stall2", 0, 1, 1, 1, 1, 1, 0, 0, 200);
    check("stall_hold", 32'(sq_if.ProgCtr), 32'd100);

    // PC wrap, halt, ignored controls in DONE, restart
    cyc("jmpmax", 0, 0, 0, 0, 0, 1, 0, 0, PC_MOD - 1);
    idle("wrap", 1);
    cyc("call_wrap", 0, 0, 0, 0, 1, 0, 0, 0, PC_MOD - 1);
    cyc("ret_wrap", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("halt", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("done_ign", 0, 0, 1, 1, 1, 1, 1, 1, 55);
    cyc("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("ret_empty", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("start_ovr", 1, 1, 0, 0, 0, 1, 0, 0, 77);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      bit st;
      st = (m_state != 1) ? ($urandom_range(3) == 0) : ($urandom_range(59) == 0);
      cyc("rand", st, $urandom_range(5) == 0, $urandom_range(15) == 0,
          $urandom_range(4) == 0, $urandom_range(4) == 0, $urandom_range(9) == 0,
          $urandom_range(3) == 0, 1'($urandom), $urandom_range(PC_MOD - 1));
    end

    // Async reset mid-RUN at ProgCtr=9
    cyc("start2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("push", 0, 0, 0, 0, 1, 0, 0, 0, 1);
    idle("to9", 8);
    check("pre_arst_pc", 32'(sq_if.ProgCtr), 32'd9);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    #2 rst = 1'b0;
    idle("post_arst", 2);
    cyc("start3", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("ret_after_arst", 0, 0, 0, 1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
